// File: rtl/pipe_decode_if.sv
// Decode-stage bundle: IF/ID handshake, decoded controls, writeback port,
// and the ID/EX register outputs toward EX.
interface pipe_decode_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       instr;
    logic [1:0]        imm_size;
    logic              reg_src;
    logic              mem_op;
    logic              mem_read;
    logic              reg_write;
    logic              src1_used;
    logic              src2_used;
    logic              wb_we;
    logic [3:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_rd1;
    logic [DATA_W-1:0] out_rd2;
    logic [3:0]        out_src1;
    logic [3:0]        out_src2;
    logic [3:0]        out_dst;
    logic              out_mem_read;
    logic              out_reg_write;
    logic              stall;

    // Upstream/EX side: drives the instruction, writeback and out_ready.
    modport master (
        output in_valid, instr, imm_size, reg_src, mem_op, mem_read, reg_write,
               src1_used, src2_used, wb_we, wb_addr, wb_data, flush, out_ready,
        input  in_ready, out_valid, out_imm, out_rd1, out_rd2, out_src1,
               out_src2, out_dst, out_mem_read, out_reg_write, stall
    );

    // Decode stage itself.
    modport slave (
        input  in_valid, instr, imm_size, reg_src, mem_op, mem_read, reg_write,
               src1_used, src2_used, wb_we, wb_addr, wb_data, flush, out_ready,
        output in_ready, out_valid, out_imm, out_rd1, out_rd2, out_src1,
               out_src2, out_dst, out_mem_read, out_reg_write, stall
    );
endinterface

// File: rtl/pipe_decode.sv
// Instruction decode stage: 16-entry register file with optional
// write-through, immediate generation, load-use hazard detection and the
// ID/EX pipeline register with valid/ready flow control.
module pipe_decode #(
    parameter int DATA_W   = 16,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input logic          clk,
    input logic          rst,
    pipe_decode_if.slave bus
);
    logic [DATA_W-1:0] rf [16];
    logic [3:0]        src1, src2, dst;
    logic [DATA_W-1:0] rd1, rd2, imm;
    logic              hazard, in_ready, accept, wb_ok;

    logic              v_q, mr_q, rw_q;
    logic [DATA_W-1:0] imm_q, rd1_q, rd2_q;
    logic [3:0]        src1_q, src2_q, dst_q;

    // Opcode nibble is decoded upstream; it is not needed here.
    logic unused_opcode;
    assign unused_opcode = ^bus.instr[15:12];

    assign src1 = bus.instr[7:4];
    assign dst  = bus.instr[11:8];
    assign src2 = bus.reg_src ? bus.instr[11:8] : bus.instr[3:0];

    // R0 is hard-wired when ZERO_REG is set, so its writes are dropped.
    assign wb_ok = bus.wb_we && !((ZERO_REG != 0) && (bus.wb_addr == 4'd0));

    // Register file: reset clears every entry and also masks a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (wb_ok) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Read ports with optional write-through of the in-flight writeback.
    always_comb begin
        rd1 = rf[src1];
        rd2 = rf[src2];
        if ((BYPASS != 0) && bus.wb_we && (bus.wb_addr == src1)) rd1 = bus.wb_data;
        if ((BYPASS != 0) && bus.wb_we && (bus.wb_addr == src2)) rd2 = bus.wb_data;
        if ((ZERO_REG != 0) && (src1 == 4'd0)) rd1 = '0;
        if ((ZERO_REG != 0) && (src2 == 4'd0)) rd2 = '0;
    end

    // Immediate: LLB/LHB patch one byte of the src2 value; memory ops scale by 2.
    always_comb begin
        imm = rd2;
        case (bus.imm_size)
            2'b00:   imm = {{(DATA_W-4){bus.instr[3]}}, bus.instr[3:0]};
            2'b01:   imm = {{(DATA_W-9){bus.instr[8]}}, bus.instr[8:0]};
            2'b10:   imm[7:0]  = bus.instr[7:0];
            default: imm[15:8] = bus.instr[7:0];
        endcase
        if (bus.mem_op) imm = {imm[DATA_W-2:0], 1'b0};
    end

    // Load-use: a load in ID/EX feeding a source here must wait one cycle.
    // A load into hard-wired R0 never produces a value worth waiting for.
    always_comb begin
        hazard = bus.in_valid && v_q && mr_q && rw_q &&
                 ((bus.src1_used && (src1 == dst_q)) ||
                  (bus.src2_used && (src2 == dst_q))) &&
                 !((ZERO_REG != 0) && (dst_q == 4'd0));
        in_ready = !rst && (bus.flush || (!hazard && (!v_q || bus.out_ready)));
        accept   = bus.in_valid && in_ready && !bus.flush;
    end

    // ID/EX register: rst > flush > hazard > accept > drain > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= 1'b0;
            mr_q   <= 1'b0;
            rw_q   <= 1'b0;
            imm_q  <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            src1_q <= '0;
            src2_q <= '0;
            dst_q  <= '0;
        end else if (bus.flush) begin
            v_q <= 1'b0;
        end else if (hazard) begin
            if (bus.out_ready) v_q <= 1'b0;
        end else if (accept) begin
            v_q    <= 1'b1;
            mr_q   <= bus.mem_read;
            rw_q   <= bus.reg_write;
            imm_q  <= imm;
            rd1_q  <= rd1;
            rd2_q  <= rd2;
            src1_q <= src1;
            src2_q <= src2;
            dst_q  <= dst;
        end else if (v_q && bus.out_ready && !bus.in_valid) begin
            v_q <= 1'b0;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.stall         = hazard;
    assign bus.out_valid     = v_q;
    assign bus.out_mem_read  = mr_q;
    assign bus.out_reg_write = rw_q;
    assign bus.out_imm       = imm_q;
    assign bus.out_rd1       = rd1_q;
    assign bus.out_rd2       = rd2_q;
    assign bus.out_src1      = src1_q;
    assign bus.out_src2      = src2_q;
    assign bus.out_dst       = dst_q;
endmodule

// File: tb/tb_pipe_decode.sv
// Directed bench for pipe_decode: three instances (default, BYPASS=0,
// ZERO_REG=1) share one stimulus stream.
module tb_pipe_decode;
    logic        clk, rst;
    logic        in_valid, reg_src, mem_op, mem_read, reg_write;
    logic        src1_used, src2_used, wb_we, flush, out_ready;
    logic [15:0] instr, wb_data;
    logic [1:0]  imm_size;
    logic [3:0]  wb_addr;
    int checks = 0;
    int errors = 0;

    pipe_decode_if #(.DATA_W(16)) ifa ();
    pipe_decode_if #(.DATA_W(16)) ifb ();
    pipe_decode_if #(.DATA_W(16)) ifz ();

`define TB_DRIVE(IFX) \
    assign IFX.in_valid  = in_valid;  \
    assign IFX.instr     = instr;     \
    assign IFX.imm_size  = imm_size;  \
    assign IFX.reg_src   = reg_src;   \
    assign IFX.mem_op    = mem_op;    \
    assign IFX.mem_read  = mem_read;  \
    assign IFX.reg_write = reg_write; \
    assign IFX.src1_used = src1_used; \
    assign IFX.src2_used = src2_used; \
    assign IFX.wb_we     = wb_we;     \
    assign IFX.wb_addr   = wb_addr;   \
    assign IFX.wb_data   = wb_data;   \
    assign IFX.flush     = flush;     \
    assign IFX.out_ready = out_ready;

    `TB_DRIVE(ifa)
    `TB_DRIVE(ifb)
    `TB_DRIVE(ifz)

    pipe_decode #(.DATA_W(16), .ZERO_REG(0), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    pipe_decode #(.DATA_W(16), .ZERO_REG(0), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    pipe_decode #(.DATA_W(16), .ZERO_REG(1), .BYPASS(1)) dut_z (.clk(clk), .rst(rst), .bus(ifz));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; in_valid = 0; instr = 0; imm_size = 0; reg_src = 0; mem_op = 0;
        mem_read = 0; reg_write = 0; src1_used = 0; src2_used = 0; flush = 0;
        out_ready = 1;
        // writeback during reset must be dropped
        wb_we = 1; wb_addr = 4'd4; wb_data = 16'h5555;
        step();
        #1;
        chk("rst_in_ready", ifa.in_ready, 0);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_out_imm", ifa.out_imm, 0);

        // basic decode: R3=0x1234 then instr 0x0A34
        rst = 0; wb_addr = 4'd3; wb_data = 16'h1234;
        step();
        wb_we = 0; in_valid = 1; instr = 16'h0A34; src1_used = 1;
        #1 chk("idle_in_ready", ifa.in_ready, 1);
        step();
        chk("basic_valid", ifa.out_valid, 1);
        chk("basic_rd1", ifa.out_rd1, 16'h1234);
        chk("basic_imm", ifa.out_imm, 16'h0004);
        chk("basic_dst", ifa.out_dst, 4'hA);
        chk("basic_src2", ifa.out_src2, 4'h4);
        chk("rst_wb_suppressed", ifa.out_rd2, 0);

        // write-through vs old value
        in_valid = 0; wb_we = 1; wb_addr = 4'd5; wb_data = 16'h1111;
        step();
        wb_data = 16'hBEEF; in_valid = 1; instr = 16'h0050;
        step();
        chk("bypass_on_rd1", ifa.out_rd1, 16'hBEEF);
        chk("bypass_off_rd1", ifb.out_rd1, 16'h1111);

        // immediates
        in_valid = 0; wb_addr = 4'd6; wb_data = 16'h00CD;
        step();
        wb_we = 0; in_valid = 1; instr = 16'h06AB; reg_src = 1; imm_size = 2'b11;
        step();
        chk("lhb_imm", ifa.out_imm, 16'hABCD);
        chk("lhb_rd2", ifa.out_rd2, 16'h00CD);
        chk("lhb_src2", ifa.out_src2, 4'h6);
        instr = 16'h01FF; reg_src = 0; imm_size = 2'b01; mem_op = 1;
        step();
        chk("imm9_memop", ifa.out_imm, 16'hFFFE);
        instr = 16'h06AB; reg_src = 1; imm_size = 2'b10; mem_op = 0;
        step();
        chk("llb_imm", ifa.out_imm, 16'h00AB);
        instr = 16'h0008; reg_src = 0; imm_size = 2'b00; mem_op = 1;
        step();
        chk("imm4_neg_memop", ifa.out_imm, 16'hFFF0);

        // load-use hazard
        instr = 16'h0200; mem_op = 0; mem_read = 1; reg_write = 1; src1_used = 0;
        step();
        chk("load_valid", ifa.out_valid, 1);
        chk("load_mem_read", ifa.out_mem_read, 1);
        chk("load_dst", ifa.out_dst, 4'h2);
        instr = 16'h0020; mem_read = 0; src1_used = 1;
        #1;
        chk("hz_stall", ifa.stall, 1);
        chk("hz_in_ready", ifa.in_ready, 0);
        step();
        chk("hz_bubble", ifa.out_valid, 0);
        chk("hz_stall_clear", ifa.stall, 0);
        chk("hz_in_ready_back", ifa.in_ready, 1);
        step();
        chk("hz_issue_valid", ifa.out_valid, 1);
        chk("hz_issue_src1", ifa.out_src1, 4'h2);
        chk("hz_issue_mem_read", ifa.out_mem_read, 0);

        // hold for 3 cycles while R2 is overwritten; snapshot must not move
        out_ready = 0; instr = 16'h0130; wb_we = 1; wb_addr = 4'd2; wb_data = 16'h9999;
        #1 chk("hold_in_ready", ifa.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            wb_we = 0;
            chk("hold_valid", ifa.out_valid, 1);
            chk("hold_src1", ifa.out_src1, 4'h2);
            chk("hold_rd1", ifa.out_rd1, 0);
            chk("hold_in_ready_n", ifa.in_ready, 0);
        end
        flush = 1;
        #1 chk("flush_in_ready", ifa.in_ready, 1);
        step();
        chk("flush_valid", ifa.out_valid, 0);

        // write during hold landed; then drain
        flush = 0; out_ready = 1; instr = 16'h0020;
        step();
        chk("post_hold_rd1", ifa.out_rd1, 16'h9999);
        chk("post_hold_valid", ifa.out_valid, 1);
        in_valid = 0;
        step();
        chk("drain_valid", ifa.out_valid, 0);

        // hard-wired R0
        wb_we = 1; wb_addr = 4'd0; wb_data = 16'h7777;
        step();
        wb_we = 0; in_valid = 1; instr = 16'h0000;
        step();
        chk("zr_rd1", ifz.out_rd1, 0);
        chk("r0_plain_rd1", ifa.out_rd1, 16'h7777);
        mem_read = 1; src1_used = 0;
        step();
        chk("zr_load_mem_read", ifz.out_mem_read, 1);
        chk("zr_load_dst", ifz.out_dst, 0);
        mem_read = 0; src1_used = 1;
        #1;
        chk("zr_no_stall", ifz.stall, 0);
        chk("zr_in_ready", ifz.in_ready, 1);
        chk("r0_plain_stall", ifa.stall, 1);
        step();
        chk("zr_issue_valid", ifz.out_valid, 1);
        chk("r0_plain_bubble", ifa.out_valid, 0);

        // reset while holding
        in_valid = 0; out_ready = 0;
        step();
        chk("zr_hold_valid", ifz.out_valid, 1);
        rst = 1;
        #1 chk("rst_in_ready_again", ifa.in_ready, 0);
        step();
        chk("rst_hold_valid", ifz.out_valid, 0);
        chk("rst_hold_reg_write", ifz.out_reg_write, 0);
        rst = 0; out_ready = 1; in_valid = 1; instr = 16'h0020;
        step();
        chk("rst_rf_cleared", ifa.out_rd1, 0);
        chk("rst_after_valid", ifa.out_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_decode.md
PIPE_DECODE -- requirements
Module: pipe_decode

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, datapath and register width; legal values are 16 or greater.
REQ-002 The block SHALL have parameter ZERO_REG, default 0; when 1, R0 reads 0 and writes to R0 are ignored.
REQ-003 The block SHALL have parameter BYPASS, default 1; when 1, a same-cycle writeback to a source register is visible on read (write-through).
REQ-004 Ports SHALL be:
clk  in  1  sole clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  decoded instruction offered
in_ready  out  1  instruction accepted this cycle when in_valid=1
instr  in  16  instruction word
imm_size  in  2  00 imm4 sext, 01 imm9 sext, 10 LLB, 11 LHB
reg_src  in  1  1: src2=instr[11:8], 0: src2=instr[3:0]
mem_op  in  1  immediate is shifted left 1
mem_read  in  1  instruction is a load
reg_write  in  1  instruction writes dst
src1_used, src2_used  in  1 each  source operand consumed
wb_we  in  1  writeback enable
wb_addr  in  4  writeback register
wb_data  in  DATA_W  writeback data
flush  in  1  squash the ID/EX stage
out_valid  out  1  ID/EX register holds an instruction
out_ready  in  1  EX accepts the ID/EX contents
out_imm, out_rd1, out_rd2  out  DATA_W each  immediate and operands
out_src1, out_src2, out_dst  out  4 each  register numbers
out_mem_read, out_reg_write  out  1 each  control passed to EX
stall  out  1  load-use hazard detected this cycle

Function
REQ-005 Fields SHALL be src1=instr[7:4], dst=instr[11:8], src2 per reg_src.
REQ-006 The register file SHALL hold 16 entries of DATA_W bits, with writes on the clk edge when wb_we=1.
REQ-007 With BYPASS=1, a read of wb_addr while wb_we=1 SHALL return wb_data; with BYPASS=0, it SHALL return the old value.
REQ-008 imm SHALL be formed as follows: 00 -> sext(instr[3:0]); 01 -> sext(instr[8:0]); 10 -> rd2 with bits[7:0]=instr[7:0]; 11 -> rd2 with bits[15:8]=instr[7:0]; all to DATA_W, where rd2 is the bypassed src2 value.
REQ-009 When mem_op=1, imm SHALL be shifted left 1 and truncated to DATA_W.
REQ-010 hazard SHALL be asserted when in_valid & out_valid & out_mem_read & out_reg_write & ((src1_used & src1==out_dst) | (src2_used & src2==out_dst)) and NOT (ZERO_REG & out_dst==0); stall SHALL equal hazard.
REQ-011 in_ready SHALL equal flush | (!hazard & (!out_valid | out_ready)), and SHALL be combinational.
REQ-012 ID/EX update priority SHALL be: rst > flush > hazard > accept > drain > hold.
REQ-013 On flush, out_valid SHALL become 0 next cycle, and an instruction offered in that cycle SHALL be consumed and discarded.
REQ-014 On hazard with out_ready=1, out_valid SHALL become 0 (bubble inserted) and IF/ID SHALL be held; on hazard with out_ready=0, the ID/EX contents SHALL be held.
REQ-015 On accept (in_valid & in_ready, no flush), all out_* SHALL load the decoded values and out_valid SHALL become 1 next cycle (latency 1).
REQ-016 On drain (out_valid & out_ready & !in_valid), out_valid SHALL become 0; on hold (out_valid & !out_ready), all out_* SHALL be stable.
REQ-017 out_rd1/out_rd2 SHALL be snapshots taken at acceptance; later writebacks SHALL NOT alter held outputs, since forwarding in EX covers them.
REQ-018 Register file writes SHALL proceed regardless of flush, stall or out_ready.

Reset
REQ-019 On rst, all 16 registers, out_valid and every out_* SHALL be 0 after the edge.
REQ-020 A wb_we asserted in the same cycle as rst SHALL be suppressed.
REQ-021 During rst, in_ready SHALL be 0.
REQ-022 rst during a stall or hold SHALL discard the pending instruction.

Verification
REQ-023 Bench SHALL cover: wb R3=0x1234, then decode instr 0x0A34 (src1=3), imm_size 00 -> next cycle out_rd1=0x1234, out_imm=0x0004, out_valid=1.
REQ-024 Bench SHALL cover: same cycle wb_we R5=0xBEEF while decoding src1=5; BYPASS=1 -> out_rd1=0xBEEF; BYPASS=0 -> old R5.
REQ-025 Bench SHALL cover: load (dst=R2) in ID/EX, next instruction src1=R2 used, out_ready=1 -> stall=1, in_ready=0, bubble out_valid=0 for one cycle, then instruction issues.
REQ-026 Bench SHALL cover: imm_size 11 with instr[7:0]=0xAB and R(src2)=0x00CD -> out_imm=0xABCD; imm_size 01, instr[8:0]=0x1FF, mem_op=1 -> 0xFFFE.
REQ-027 Bench SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0; flush asserted -> out_valid=0 next cycle.
REQ-028 Bench SHALL cover: ZERO_REG=1, write 0x7777 to R0 -> R0 reads 0, and a load to R0 raises no stall.
